// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised single-clock FIFO with registered status, thresholds, flush and sticky errors
// Optional feature macro: PARAM_FIFO_FWFT_EN (first-word-fall-through read port)
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 2,
  parameter int AF_THRESH = 2**ADDR_W-1,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO    = '0;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            af_q, af_d;
  logic            ae_q, ae_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            wr_acc;
  logic            rd_acc;
  logic [ADDR_W-1:0] rd_idx;

  // Acceptance looks only at registered flags; a flush swallows both requests.
  assign wr_acc = wr_en && !full_q  && !clr;
  assign rd_acc = rd_en && !empty_q && !clr;
  assign rd_idx = rd_ptr_q[ADDR_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr) begin
      wr_ptr_d = ZERO;
      rd_ptr_d = ZERO;
      count_d  = ZERO;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      count_d = count_q + (wr_acc ? ONE : ZERO) - (rd_acc ? ONE : ZERO);
      ovf_d   = ovf_q | (wr_en & full_q);
      unf_d   = unf_q | (rd_en & empty_q);
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == ZERO);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= ZERO;
      rd_ptr_q <= ZERO;
      count_q  <= ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage carries no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign rd_data  = empty_q ? '0 : mem_q[rd_idx];
  assign rd_valid = !empty_q;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) rd_data_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo (depth 4, byte wide) against a queue model
module tb_param_fifo;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  param_fifo #(.WIDTH(8), .ADDR_W(2), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue plus sticky bits, updated from the pre-edge occupancy.
  logic [7:0] mq[$];
  bit         m_ovf, m_unf, m_valid;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_valid = 0; m_data = 8'h00;
    end else if (clr) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_valid = 0;
    end else begin
      int sz;
      sz = mq.size();
      m_valid = 0;
      if (wr_en && sz == DEPTH) m_ovf = 1;
      if (rd_en && sz == 0) m_unf = 1;
      if (rd_en && sz != 0) begin
        m_data  = mq.pop_front();
        m_valid = 1;
      end
      if (wr_en && sz != DEPTH) mq.push_back(wr_data);
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      int sz;
      sz = mq.size();
      chk("count", count, sz);
      chk("empty", empty, sz == 0);
      chk("full", full, sz == DEPTH);
      chk("almost_full", almost_full, sz >= AF);
      chk("almost_empty", almost_empty, sz <= AE);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
`ifdef PARAM_FIFO_FWFT_EN
      chk("rd_valid", rd_valid, sz != 0);
      chk("rd_data", rd_data, (sz != 0) ? mq[0] : 8'h00);
`else
      chk("rd_valid", rd_valid, m_valid);
      chk("rd_data", rd_data, m_data);
`endif
    end
  end

  // Apply one cycle of inputs, return 1 time unit after the edge that consumed them.
  task automatic drive(input logic w, input logic [7:0] wd, input logic r, input logic c);
    wr_en = w; wr_data = wd; rd_en = r; clr = c;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; clr = 0;
  endtask

  initial begin
    logic [7:0] d;
    #12;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_ae", almost_empty, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    cmp_en = 1;

    // Asynchronous reset between edges with data in flight.
    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    chk("pre_rst_count", count, 2);
    #2 rst_n = 0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_data", rd_data, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Fill then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hA0 + 8'(i), 0, 0);
      if (i == 1) chk("af_after2", almost_full, 0);
      if (i == 2) chk("af_after3", almost_full, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef PARAM_FIFO_FWFT_EN
      chk("drain_data", rd_data, 8'hA0 + 8'(i));
      drive(0, 8'h00, 1, 0);
`else
      drive(0, 8'h00, 1, 0);
      chk("drain_data", rd_data, 8'hA0 + 8'(i));
      chk("drain_valid", rd_valid, 1);
`endif
    end
    chk("drain_empty", empty, 1);

    // Overflow / underflow / flush.
    for (int i = 0; i < 5; i++) drive(1, 8'h30 + 8'(i), 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0);
    chk("unf_set", underflow, 1);
    chk("unf_rd_valid", rd_valid, 0);
    chk("unf_ovf_sticky", overflow, 1);
    drive(0, 8'h00, 0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);
    chk("clr_count", count, 0);

    // Simultaneous read/write at occupancy 2 across pointer wrap.
    drive(1, 8'd0, 0, 0);
    drive(1, 8'd1, 0, 0);
    for (int i = 0; i < 10; i++) begin
`ifdef PARAM_FIFO_FWFT_EN
      chk("rw_head", rd_data, i);
      drive(1, 8'(i + 2), 1, 0);
`else
      drive(1, 8'(i + 2), 1, 0);
      chk("rw_data", rd_data, i);
`endif
      chk("rw_count", count, 2);
    end

    // Full with simultaneous read and write.
    drive(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 8'h40 + 8'(i), 0, 0);
    drive(1, 8'h99, 1, 0);
    chk("fullrw_count", count, 3);
    chk("fullrw_ovf", overflow, 1);
    chk("fullrw_full", full, 0);

`ifdef PARAM_FIFO_FWFT_EN
    drive(0, 8'h00, 0, 1);
    drive(1, 8'h5C, 0, 0);
    chk("fwft_data", rd_data, 8'h5C);
    chk("fwft_valid", rd_valid, 1);
    drive(0, 8'h00, 1, 0);
    chk("fwft_empty", empty, 1);
    chk("fwft_zero", rd_data, 0);
`endif

    // Randomized traffic, with write/read bias shifting per segment.
    for (int seg = 0; seg < 8; seg++) begin
      int wp;
      wp = (seg % 2 == 0) ? 75 : 25;
      for (int k = 0; k < 250; k++) begin
        d = 8'($urandom);
        drive($urandom_range(99) < wp, d, $urandom_range(99) >= wp - 10,
              $urandom_range(63) == 0);
      end
    end

    cmp_en = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
